// File: rtl/divider_multicycle_pkg.sv
// Shared types and constants for the multicycle restoring divider.
// i64/u65 are raw bit vectors: signedness is applied explicitly by the logic.
package divider_multicycle_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    typedef logic [XLEN-1:0] i64;
    typedef logic [XLEN:0]   u65;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [CNT_W-1:0] DIV_ITER_64 = 7'd64;
    localparam logic [CNT_W-1:0] DIV_ITER_32 = 7'd32;

    function automatic i64 sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic i64 zext32(input logic [31:0] v);
        return {32'd0, v};
    endfunction

    function automatic i64 neg_if(input i64 v, input logic n);
        return n ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/divider_multicycle_if.sv
// Request/response bundle between the issuing stage and the divider.
interface divider_multicycle_if;
    import divider_multicycle_pkg::*;

    logic valid;
    logic is_signed;
    logic is_word;
    i64   a;
    i64   b;
    logic done;
    logic busy;
    i64   q;
    i64   r;

    modport master (
        output valid, is_signed, is_word, a, b,
        input  done, busy, q, r
    );

    modport slave (
        input  valid, is_signed, is_word, a, b,
        output done, busy, q, r
    );

endinterface

// File: rtl/divider_multicycle_operand_prep.sv
// Operand conditioning: W-form extension, magnitudes, result signs, and the
// single-cycle results for division by zero and signed overflow.
module div_operand_prep
    import divider_multicycle_pkg::*;
(
    input  logic is_signed_i,
    input  logic is_word_i,
    input  i64   a_i,
    input  i64   b_i,
    output i64   a_mag_o,
    output i64   b_mag_o,
    output logic q_neg_o,
    output logic r_neg_o,
    output logic fast_o,
    output i64   fast_q_o,
    output i64   fast_r_o
);

    i64   a_ext_s;
    i64   b_ext_s;
    i64   min_s;
    i64   a_res_s;
    logic a_sgn_s;
    logic b_sgn_s;
    logic zero_s;
    logic ovf_s;

    // Extend, take magnitudes and classify the special cases.
    always_comb begin
        if (is_word_i) begin
            a_ext_s = is_signed_i ? sext32(a_i[31:0]) : zext32(a_i[31:0]);
            b_ext_s = is_signed_i ? sext32(b_i[31:0]) : zext32(b_i[31:0]);
            min_s   = sext32(32'h8000_0000);
            a_res_s = sext32(a_i[31:0]);
        end else begin
            a_ext_s = a_i;
            b_ext_s = b_i;
            min_s   = {1'b1, 63'd0};
            a_res_s = a_i;
        end

        a_sgn_s = is_signed_i & a_ext_s[XLEN-1];
        b_sgn_s = is_signed_i & b_ext_s[XLEN-1];
        a_mag_o = neg_if(a_ext_s, a_sgn_s);
        b_mag_o = neg_if(b_ext_s, b_sgn_s);
        q_neg_o = a_sgn_s ^ b_sgn_s;
        r_neg_o = a_sgn_s;

        zero_s  = (b_ext_s == 64'd0);
        ovf_s   = is_signed_i & (a_ext_s == min_s) & (b_ext_s == {64{1'b1}});
        fast_o  = zero_s | ovf_s;

        // W-form fast results are sign-extended from bit 31 even when unsigned.
        if (zero_s) begin
            fast_q_o = {64{1'b1}};
            fast_r_o = a_res_s;
        end else if (ovf_s) begin
            fast_q_o = a_res_s;
            fast_r_o = 64'd0;
        end else begin
            fast_q_o = 64'd0;
            fast_r_o = 64'd0;
        end
    end

endmodule

// File: rtl/divider_multicycle.sv
// Iterative restoring divider: one quotient bit per cycle, with a one-cycle
// path for divide-by-zero and signed overflow.
module divider_multicycle
    import divider_multicycle_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    divider_multicycle_if.slave   bus
);

    div_state_t       state_q,  state_d;
    logic [CNT_W-1:0] count_q,  count_d;
    i64               quo_q,    quo_d;
    i64               rem_q,    rem_d;
    i64               div_q,    div_d;
    logic             q_neg_q,  q_neg_d;
    logic             r_neg_q,  r_neg_d;
    logic             word_q,   word_d;
    logic             done_q,   done_d;
    logic             busy_q,   busy_d;
    i64               q_q,      q_d;
    i64               r_q,      r_d;

    i64   a_mag_s;
    i64   b_mag_s;
    logic q_neg_s;
    logic r_neg_s;
    logic fast_s;
    i64   fast_q_s;
    i64   fast_r_s;

    u65               rem_sh_s;
    u65               diff_s;
    logic             ge_s;
    i64               quo_nx_s;
    i64               rem_nx_s;
    logic [CNT_W-1:0] cnt_nx_s;
    i64               q_sc_s;
    i64               r_sc_s;
    i64               q_fix_s;
    i64               r_fix_s;

    div_operand_prep u_prep (
        .is_signed_i (bus.is_signed),
        .is_word_i   (bus.is_word),
        .a_i         (bus.a),
        .b_i         (bus.b),
        .a_mag_o     (a_mag_s),
        .b_mag_o     (b_mag_s),
        .q_neg_o     (q_neg_s),
        .r_neg_o     (r_neg_s),
        .fast_o      (fast_s),
        .fast_q_o    (fast_q_s),
        .fast_r_o    (fast_r_s)
    );

    // One restoring step; the shifted remainder keeps its carry-out so that
    // divisors with bit 63 set still compare correctly.
    always_comb begin
        rem_sh_s = {rem_q, quo_q[XLEN-1]};
        ge_s     = (rem_sh_s >= {1'b0, div_q});
        diff_s   = rem_sh_s - {1'b0, div_q};
        quo_nx_s = {quo_q[XLEN-2:0], ge_s};
        rem_nx_s = ge_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
        cnt_nx_s = count_q - 7'd1;
        q_sc_s   = neg_if(quo_nx_s, q_neg_q);
        r_sc_s   = neg_if(rem_nx_s, r_neg_q);
        if (word_q) begin
            q_fix_s = sext32(q_sc_s[31:0]);
            r_fix_s = sext32(r_sc_s[31:0]);
        end else begin
            q_fix_s = q_sc_s;
            r_fix_s = r_sc_s;
        end
    end

    // Next-state and output decode; flush overrides everything but q/r.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        word_d  = word_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        q_d     = q_q;
        r_d     = r_q;

        if (flush) begin
            state_d = IDLE;
            count_d = 7'd0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid) begin
                        q_neg_d = q_neg_s;
                        r_neg_d = r_neg_s;
                        word_d  = bus.is_word;
                        busy_d  = 1'b1;
                        if (fast_s) begin
                            state_d = DONE;
                            count_d = 7'd0;
                            done_d  = 1'b1;
                            q_d     = fast_q_s;
                            r_d     = fast_r_s;
                        end else begin
                            state_d = BUSY;
                            rem_d   = 64'd0;
                            if (bus.is_word) begin
                                count_d = DIV_ITER_32;
                                quo_d   = {a_mag_s[31:0], 32'd0};
                                div_d   = zext32(b_mag_s[31:0]);
                            end else begin
                                count_d = DIV_ITER_64;
                                quo_d   = a_mag_s;
                                div_d   = b_mag_s;
                            end
                        end
                    end else begin
                        busy_d = 1'b0;
                    end
                end
                BUSY: begin
                    quo_d   = quo_nx_s;
                    rem_d   = rem_nx_s;
                    count_d = cnt_nx_s;
                    if (cnt_nx_s == 7'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        q_d     = q_fix_s;
                        r_d     = r_fix_s;
                    end else begin
                        state_d = BUSY;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    count_d = 7'd0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            count_q <= 7'd0;
            quo_q   <= 64'd0;
            rem_q   <= 64'd0;
            div_q   <= 64'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            word_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            q_q     <= 64'd0;
            r_q     <= 64'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            word_q  <= word_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.q    = q_q;
    assign bus.r    = r_q;

endmodule

// File: tb/tb_divider_multicycle.sv
// Scoreboard bench for divider_multicycle: directed vectors push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_divider_multicycle;
    import divider_multicycle_pkg::*;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        flush  = 1'b0;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_q = 64'd0;
    logic [63:0] last_r = 64'd0;
    exp_t        sb[$];

    divider_multicycle_if bus();

    divider_multicycle dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (resetn && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {63'd0, bus.done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_q"}, bus.q, e.q);
                chk({e.name, "_r"}, bus.r, e.r);
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk({nm, "_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(posedge clk);
    endtask

    task automatic issue(input string nm, input bit sg, input bit wd,
                         input logic [63:0] av, input logic [63:0] bv,
                         input logic [63:0] eq, input logic [63:0] er, input int lat);
        exp_t e;
        @(posedge clk); #1;
        bus.valid     = 1'b1;
        bus.is_signed = sg;
        bus.is_word   = wd;
        bus.a         = av;
        bus.b         = bv;
        e.q = eq; e.r = er; e.cyc = cyc + lat; e.name = nm;
        sb.push_back(e);
        last_q = eq;
        last_r = er;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        wait_drain(nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        exp_t e;
        bus.valid = 1'b0; bus.is_signed = 1'b0; bus.is_word = 1'b0;
        bus.a = 64'd0; bus.b = 64'd0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_q", bus.q, 64'd0);
        chk("reset_r", bus.r, 64'd0);

        issue("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
        issue("div_m7_2", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        issue("div_7_m2", 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
              64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
        issue("div_m100_m7", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
              64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        issue("divu_big", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
              64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 65);
        issue("divu_zero", 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
        issue("div_zero_neg", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1);
        issue("div_ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 64'd0, 1);
        issue("divw_ovf", 1'b1, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 64'd0, 1);
        issue("divuw_ffff_2", 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2,
              64'h0000_0000_7FFF_FFFF, 64'd1, 33);
        issue("divw_m7_2", 1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        issue("divuw_sext", 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'd1,
              64'hFFFF_FFFF_8000_0000, 64'd0, 33);
        issue("divuw_zero", 1'b0, 1'b1, 64'hABCD_0000_8000_0001, 64'h0000_0005_0000_0000,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1);

        // Flush mid-operation: no done, results keep their previous values.
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.is_signed = 1'b0; bus.is_word = 1'b0;
        bus.a = 64'd100; bus.b = 64'd7;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        chk("flush_busy_start", {63'd0, bus.busy}, 64'd1);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {63'd0, bus.busy}, 64'd0);
        chk("flush_q_hold", bus.q, last_q);
        chk("flush_r_hold", bus.r, last_r);
        repeat (80) @(posedge clk);

        // Reset mid-operation: outputs cleared, no done.
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.a = 64'd1000; bus.b = 64'd3;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        repeat (19) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_mid_q", bus.q, 64'd0);
        chk("rst_mid_r", bus.r, 64'd0);
        chk("rst_mid_done", {63'd0, bus.done}, 64'd0);
        chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
        repeat (80) @(posedge clk);

        // Back-to-back with valid held; operands change during the first op.
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.is_signed = 1'b0; bus.is_word = 1'b0;
        bus.a = 64'd1000; bus.b = 64'd10;
        c = cyc;
        e.q = 64'd100; e.r = 64'd0; e.cyc = c + 65; e.name = "b2b_first";
        sb.push_back(e);
        e.q = 64'd16; e.r = 64'd2; e.cyc = c + 131; e.name = "b2b_second";
        sb.push_back(e);
        @(posedge clk); #1;
        bus.a = 64'd50; bus.b = 64'd3;
        repeat (66) @(posedge clk);
        #1 bus.valid = 1'b0;
        bus.a = 64'd9; bus.b = 64'd9;
        wait_drain("b2b");

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
